mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single external memory port between the instruction-cache refill path and the data-cache path.
- Serves instruction line refills as wrapping bursts, critical word first.
- Serves data line reads as wrapping bursts and data writes as single beats.
- Arbitrates round-robin between the two requesters, one transaction at a time.
- Sits between the two cache controllers and the memory interface. While a refill is in progress, the instruction cache holds the fetch stage's blocking signal low.

Parameters:
- ADDR_WIDTH, 30: word-address width, byte address bits [31:2].
- DATA_WIDTH, 32: beat width.
- BURST_LEN, 4: words per cache line; must be a power of two, at least 2.
- BEAT_W, $clog2(BURST_LEN): width of the beat counter and of the wrap field.

Ports:
- clk_i  in  1  clock; everything is sampled on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- ireq_i  in  1  instruction refill request; held high until idone_o.
- iaddr_i  in  ADDR_WIDTH  word address of the missed instruction (critical word).
- igrant_o  out  1  instruction side currently owns the memory port.
- irdata_o  out  DATA_WIDTH  refill beat data.
- irvalid_o  out  1  irdata_o is valid this cycle.
- idone_o  out  1  one-cycle pulse with the last refill beat.
- dreq_i  in  1  data request; held high until ddone_o.
- dwe_i  in  1  1 = single-beat write, 0 = line read burst.
- daddr_i  in  ADDR_WIDTH  data word address (critical word for reads).
- dwdata_i  in  DATA_WIDTH  write data.
- dgrant_o  out  1  data side currently owns the memory port.
- drdata_o  out  DATA_WIDTH  read beat data.
- drvalid_o  out  1  drdata_o is valid this cycle.
- ddone_o  out  1  one-cycle pulse with the final beat.
- mem_req_o  out  1  beat request to memory.
- mem_we_o  out  1  beat is a write.
- mem_addr_o  out  ADDR_WIDTH  beat word address.
- mem_wdata_o  out  DATA_WIDTH  beat write data.
- mem_ack_i  in  1  beat completes this cycle; read data is valid on mem_rdata_i in the same cycle.
- mem_rdata_i  in  DATA_WIDTH  memory read data.

Behaviour:
- Reset values (asynchronous, applied immediately when rst_ni goes low):
  - State = IDLE; last = DATA, so the instruction side wins the first tie.
  - All grant, valid, done and mem_req_o/mem_we_o outputs = 0.
  - Address, data and beat counter registers = 0.
- States: IDLE, BUSY_I, BUSY_D. Everything is registered; no output depends combinationally on a request input.
- IDLE transitions:
  - ireq_i and dreq_i both high: enter BUSY_D if last == INSTR, otherwise BUSY_I.
  - Only one request high: enter that side's BUSY state.
  - On the entering edge: latch address, we and wdata from the winner; set beat counter = 0; update last.
- BUSY_x outputs:
  - grant_x = 1 and mem_req_o = 1 for every cycle in the state.
  - mem_addr_o = {latched_addr[ADDR_WIDTH-1:BEAT_W], latched_addr[BEAT_W-1:0] + cnt}, with the low field adding modulo BURST_LEN (wrap within the line).
  - mem_we_o = 1 only in BUSY_D when the latched we = 1.
- Per beat (cycle with mem_ack_i = 1):
  - Reads: the owner's rdata_o = mem_rdata_i and rvalid_o = 1, registered, so both appear one cycle after the ack.
  - Counter increments.
- Last beat:
  - The last beat is cnt == BURST_LEN-1 for reads, or the first ack for a write.
  - done_x pulses together with the last rvalid, or one cycle after the write ack.
  - State returns to IDLE.
- Latency:
  - Request high to first mem_req_o = 1 cycle.
  - A mandatory one-cycle IDLE bubble separates back-to-back transactions; arbitration is re-evaluated in it.
- Without mem_ack_i, the beat holds: address and we stay stable and mem_req_o stays high, for unbounded wait states.
- A requester dropping its req mid-transaction has no effect; the transaction runs to completion.
- New requests are ignored while BUSY.
- mem_ack_i while IDLE is ignored.
- Reset mid-burst aborts immediately: no done pulse, and requesters restart after reset.

Decomposition:
- Shared package holds:
  - state encoding localparams ST_IDLE, ST_BUSY_I, ST_BUSY_D;
  - owner encodings OWNER_INSTR and OWNER_DATA.
- Sub-module: wrap_beat_counter (BEAT_W-bit counter with clear and enable, plus a last flag).
- The existing increment module may serve inside wrap_beat_counter.

Test Plan:
- Lone instruction refill:
  - Stimulus: ireq with iaddr=0x0000_0102; memory acks every cycle.
  - Response: mem_addr_o = 0x102, 0x103, 0x100, 0x101; four irvalid beats; idone_o with the 4th; igrant_o high for exactly 4 cycles.
- Simultaneous requests after reset:
  - Stimulus: ireq and dreq raised in the same cycle.
  - Response: BUSY_I first; after idone_o, one bubble, then BUSY_D.
  - Stimulus, repeated pair: both requests raised again.
  - Response: data side wins.
- Data write with wait states:
  - Stimulus: dwe=1, daddr=0x40, dwdata=0xDEADBEEF; mem_ack_i held low 3 cycles, then high.
  - Response: mem_we_o=1 and addr 0x40 stable for 4 cycles; ddone_o one cycle after the ack; no drvalid_o.
- Requester drop:
  - Stimulus: ireq_i deasserted after the 1st beat.
  - Response: all 4 beats still issued; idone_o still pulses.
- Reset mid-burst:
  - Stimulus: rst_ni pulled low after the 2nd beat.
  - Response: mem_req_o and igrant_o go to 0 without waiting for a clock edge; no idone_o. After release, a pending dreq is granted (last reset to DATA means a tie goes to INSTR).
- Stray ack:
  - Stimulus: mem_ack_i high while IDLE.
  - Response: no valid or done outputs; counter unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared types for the memory port arbiter.
//   - state_e : arbiter FSM states (idle, instruction burst, data transaction)
//   - owner_e : which requester was served most recently
//   - pick_instr() : round-robin tie-break used when leaving IDLE
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_e;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  // Instruction side wins if it is the only requester, or if both request
  // and the data side was served last.
  function automatic logic pick_instr(input logic ireq, input logic dreq,
                                      input owner_e last);
    return ireq && (!dreq || (last == OWNER_DATA));
  endfunction

endpackage

// File: rtl/mem_port_arbiter_wrap_beat_counter.sv
// ---------------------------------------------------------------------------
// wrap_beat_counter
//   BEAT_W-bit beat counter for a line burst. Counts modulo BURST_LEN, so the
//   value can be added straight onto the critical-word offset to wrap within
//   the line.
//   Ports:
//     clk_i, rst_ni : clock, asynchronous active-low reset
//     clr_i         : synchronous clear to 0 (wins over en_i)
//     en_i          : advance by one beat
//     cnt_o         : current beat index
//     last_o        : cnt_o is the final beat of the line
// ---------------------------------------------------------------------------
module wrap_beat_counter #(
  parameter int BURST_LEN = 4,
  parameter int BEAT_W    = $clog2(BURST_LEN)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [BEAT_W-1:0] cnt_o,
  output logic              last_o
);

  logic [BEAT_W-1:0] cnt_reg;
  logic [BEAT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr_i) begin
      cnt_next = '0;
    end else if (en_i) begin
      // BURST_LEN is a power of two, so natural overflow is the wrap.
      cnt_next = cnt_reg + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt_o  = cnt_reg;
  // All-ones is BURST_LEN-1 for a power-of-two line length.
  assign last_o = &cnt_reg;

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one external memory port between the instruction-cache refill path
//   and the data-cache path, one transaction at a time, round-robin.
//   Instruction refills and data reads are wrapping line bursts (critical word
//   first); data writes are single beats. Every output is driven from
//   registers, none combinationally from a request input.
//   Ports:
//     clk_i, rst_ni            : clock, asynchronous active-low reset
//     ireq_i, iaddr_i          : refill request / critical word address
//     igrant_o                 : instruction side owns the port
//     irdata_o, irvalid_o      : refill beat data (one cycle after mem ack)
//     idone_o                  : pulse with the last refill beat
//     dreq_i, dwe_i, daddr_i,
//     dwdata_i                 : data request, write flag, address, write data
//     dgrant_o                 : data side owns the port
//     drdata_o, drvalid_o      : read beat data (one cycle after mem ack)
//     ddone_o                  : pulse with the final beat / after write ack
//     mem_req_o, mem_we_o,
//     mem_addr_o, mem_wdata_o  : beat request to memory
//     mem_ack_i, mem_rdata_i   : beat completion and read data (same cycle)
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4,
  parameter int BEAT_W     = $clog2(BURST_LEN)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // instruction refill side
  input  logic                  ireq_i,
  input  logic [ADDR_WIDTH-1:0] iaddr_i,
  output logic                  igrant_o,
  output logic [DATA_WIDTH-1:0] irdata_o,
  output logic                  irvalid_o,
  output logic                  idone_o,
  // data side
  input  logic                  dreq_i,
  input  logic                  dwe_i,
  input  logic [ADDR_WIDTH-1:0] daddr_i,
  input  logic [DATA_WIDTH-1:0] dwdata_i,
  output logic                  dgrant_o,
  output logic [DATA_WIDTH-1:0] drdata_o,
  output logic                  drvalid_o,
  output logic                  ddone_o,
  // memory port
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  state_e                state_reg;
  owner_e                last_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  we_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [DATA_WIDTH-1:0] irdata_reg;
  logic [DATA_WIDTH-1:0] drdata_reg;
  logic                  irvalid_reg;
  logic                  drvalid_reg;
  logic                  idone_reg;
  logic                  ddone_reg;

  logic                  busy;
  logic                  cnt_clr;
  logic                  cnt_en;
  logic [BEAT_W-1:0]     cnt;
  logic                  cnt_last;
  logic [BEAT_W-1:0]     beat_offset;

  // -------------------------------------------------------------------------
  // Beat counter: held at zero while idle, advances on each acked beat.
  // Stray acks in IDLE therefore leave it untouched.
  // -------------------------------------------------------------------------
  assign busy    = (state_reg != ST_IDLE);
  assign cnt_clr = !busy;
  assign cnt_en  = busy && mem_ack_i;

  wrap_beat_counter #(
    .BURST_LEN (BURST_LEN),
    .BEAT_W    (BEAT_W)
  ) u_beat_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (cnt),
    .last_o (cnt_last)
  );

  // -------------------------------------------------------------------------
  // Arbitration FSM. One bubble cycle in IDLE always separates transactions,
  // and that is the only cycle in which requests are looked at.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= ST_IDLE;
      last_reg    <= OWNER_DATA;
      addr_reg    <= '0;
      we_reg      <= 1'b0;
      wdata_reg   <= '0;
      irdata_reg  <= '0;
      drdata_reg  <= '0;
      irvalid_reg <= 1'b0;
      drvalid_reg <= 1'b0;
      idone_reg   <= 1'b0;
      ddone_reg   <= 1'b0;
    end else begin
      // valid/done are single-cycle pulses
      irvalid_reg <= 1'b0;
      drvalid_reg <= 1'b0;
      idone_reg   <= 1'b0;
      ddone_reg   <= 1'b0;

      unique case (state_reg)
        ST_IDLE: begin
          if (pick_instr(ireq_i, dreq_i, last_reg)) begin
            state_reg <= ST_BUSY_I;
            last_reg  <= OWNER_INSTR;
            addr_reg  <= iaddr_i;
            we_reg    <= 1'b0;
            wdata_reg <= '0;
          end else if (dreq_i) begin
            state_reg <= ST_BUSY_D;
            last_reg  <= OWNER_DATA;
            addr_reg  <= daddr_i;
            we_reg    <= dwe_i;
            wdata_reg <= dwdata_i;
          end
        end

        ST_BUSY_I: begin
          if (mem_ack_i) begin
            irvalid_reg <= 1'b1;
            irdata_reg  <= mem_rdata_i;
            if (cnt_last) begin
              idone_reg <= 1'b1;
              state_reg <= ST_IDLE;
            end
          end
        end

        ST_BUSY_D: begin
          if (mem_ack_i) begin
            if (we_reg) begin
              // single-beat write: done one cycle after its ack, no rvalid
              ddone_reg <= 1'b1;
              state_reg <= ST_IDLE;
            end else begin
              drvalid_reg <= 1'b1;
              drdata_reg  <= mem_rdata_i;
              if (cnt_last) begin
                ddone_reg <= 1'b1;
                state_reg <= ST_IDLE;
              end
            end
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Memory-side outputs, decoded from registered state only. The low address
  // field adds the beat index modulo BURST_LEN so bursts wrap in the line.
  // -------------------------------------------------------------------------
  assign beat_offset = addr_reg[BEAT_W-1:0] + cnt;

  assign mem_req_o   = busy;
  assign mem_we_o    = (state_reg == ST_BUSY_D) && we_reg;
  assign mem_addr_o  = {addr_reg[ADDR_WIDTH-1:BEAT_W], beat_offset};
  assign mem_wdata_o = wdata_reg;

  assign igrant_o    = (state_reg == ST_BUSY_I);
  assign dgrant_o    = (state_reg == ST_BUSY_D);
  assign irdata_o    = irdata_reg;
  assign irvalid_o   = irvalid_reg;
  assign idone_o     = idone_reg;
  assign drdata_o    = drdata_reg;
  assign drvalid_o   = drvalid_reg;
  assign ddone_o     = ddone_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Inputs change 1 ns after the rising
//   edge and outputs are sampled at the same point; read data returned by the
//   memory is a fixed pattern of the address the bench expects.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          ireq;
  logic [AW-1:0] iaddr;
  logic          igrant;
  logic [DW-1:0] irdata;
  logic          irvalid;
  logic          idone;
  logic          dreq;
  logic          dwe;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dwdata;
  logic          dgrant;
  logic [DW-1:0] drdata;
  logic          drvalid;
  logic          ddone;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BURST_LEN  (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .ireq_i      (ireq),
    .iaddr_i     (iaddr),
    .igrant_o    (igrant),
    .irdata_o    (irdata),
    .irvalid_o   (irvalid),
    .idone_o     (idone),
    .dreq_i      (dreq),
    .dwe_i       (dwe),
    .daddr_i     (daddr),
    .dwdata_i    (dwdata),
    .dgrant_o    (dgrant),
    .drdata_o    (drdata),
    .drvalid_o   (drvalid),
    .ddone_o     (ddone),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata)
  );

  function automatic logic [DW-1:0] rd_pat(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ {2'b00, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs a 4-beat wrapping read burst with an ack every cycle. Entered right
  // after the edge that granted the port; returns in the IDLE bubble.
  task automatic run_burst(input bit is_i, input logic [AW-1:0] crit, input bit drop_ireq);
    logic [AW-1:0] exp_a;
    logic [1:0]    lo;
    for (int b = 0; b < 4; b++) begin
      lo    = crit[1:0] + 2'(b);
      exp_a = {crit[AW-1:2], lo};
      chk(is_i ? "owner_grant_i" : "owner_grant_d", is_i ? igrant : dgrant, 1);
      chk("other_grant", is_i ? dgrant : igrant, 0);
      chk("mem_req", mem_req, 1);
      chk("mem_we", mem_we, 0);
      chk("mem_addr", mem_addr, exp_a);
      mem_ack   = 1'b1;
      mem_rdata = rd_pat(exp_a);
      step();
      if (drop_ireq && b == 0) ireq = 1'b0;
      chk(is_i ? "irvalid" : "drvalid", is_i ? irvalid : drvalid, 1);
      chk(is_i ? "irdata" : "drdata", is_i ? irdata : drdata, rd_pat(exp_a));
      chk(is_i ? "idone" : "ddone", is_i ? idone : ddone, (b == 3) ? 1 : 0);
      chk("other_valid", is_i ? drvalid : irvalid, 0);
    end
    mem_ack = 1'b0;
    chk("bubble_igrant", igrant, 0);
    chk("bubble_dgrant", dgrant, 0);
    chk("bubble_mem_req", mem_req, 0);
    $display("burst %s crit=%0h done", is_i ? "I" : "D", crit);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni = 1'b0; ireq = 1'b0; iaddr = '0; dreq = 1'b0; dwe = 1'b0;
    daddr = '0; dwdata = '0; mem_ack = 1'b0; mem_rdata = '0;

    // ---- reset state ----
    step(); step();
    chk("rst_igrant", igrant, 0);
    chk("rst_dgrant", dgrant, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_irvalid", irvalid, 0);
    chk("rst_idone", idone, 0);
    chk("rst_drvalid", drvalid, 0);
    chk("rst_ddone", ddone, 0);
    chk("rst_irdata", irdata, 0);
    rst_ni = 1'b1;
    step();
    $display("reset released");

    // ---- lone instruction refill, critical word 0x102 ----
    ireq  = 1'b1;
    iaddr = 30'h102;
    chk("pre_grant_mem_req", mem_req, 0);
    step();
    run_burst(1'b1, 30'h102, 1'b0);
    ireq = 1'b0;
    step();
    chk("idone_single_pulse", idone, 0);
    chk("irvalid_after", irvalid, 0);

    // ---- simultaneous requests after reset ----
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    ireq  = 1'b1; iaddr = 30'h200;
    dreq  = 1'b1; daddr = 30'h300; dwe = 1'b0;
    step();
    run_burst(1'b1, 30'h200, 1'b0);
    // instruction side re-requests at once: a fresh tie, last owner was INSTR
    iaddr = 30'h204;
    step();
    run_burst(1'b0, 30'h300, 1'b0);
    dreq = 1'b0;
    // pending refill now served; requester drops ireq after the first beat
    step();
    run_burst(1'b1, 30'h204, 1'b1);
    chk("drop_ireq_low", ireq, 0);
    step();
    chk("no_new_grant_i", igrant, 0);
    chk("no_new_grant_d", dgrant, 0);

    // ---- data write with 3 wait states ----
    dreq = 1'b1; dwe = 1'b1; daddr = 30'h40; dwdata = 32'hDEAD_BEEF;
    step();
    dreq = 1'b1;
    for (int w = 0; w < 4; w++) begin
      chk("wr_dgrant", dgrant, 1);
      chk("wr_mem_req", mem_req, 1);
      chk("wr_mem_we", mem_we, 1);
      chk("wr_mem_addr", mem_addr, 30'h40);
      chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      mem_ack = (w == 3);
      step();
      chk("wr_drvalid", drvalid, 0);
      chk("wr_ddone", ddone, (w == 3) ? 1 : 0);
    end
    mem_ack = 1'b0; dreq = 1'b0; dwe = 1'b0;
    chk("wr_after_dgrant", dgrant, 0);
    step();
    chk("wr_ddone_pulse", ddone, 0);
    $display("write 0x40 done");

    // ---- stray ack while idle ----
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    step(); step();
    chk("stray_irvalid", irvalid, 0);
    chk("stray_drvalid", drvalid, 0);
    chk("stray_idone", idone, 0);
    chk("stray_ddone", ddone, 0);
    chk("stray_mem_req", mem_req, 0);
    mem_ack = 1'b0;
    $display("stray ack ignored");

    // ---- reset in the middle of a refill ----
    ireq = 1'b1; iaddr = 30'h3F1;
    step();
    // counter untouched by the stray ack: burst starts at the critical word
    chk("mid_first_addr", mem_addr, 30'h3F1);
    mem_ack = 1'b1; mem_rdata = rd_pat(30'h3F1);
    step();
    chk("mid_beat0_valid", irvalid, 1);
    chk("mid_beat1_addr", mem_addr, 30'h3F2);
    mem_rdata = rd_pat(30'h3F2);
    step();
    chk("mid_beat1_data", irdata, rd_pat(30'h3F2));
    mem_ack = 1'b0;
    dreq = 1'b1; daddr = 30'h80; dwe = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_async_mem_req", mem_req, 0);
    chk("rst_async_igrant", igrant, 0);
    chk("rst_async_idone", idone, 0);
    ireq = 1'b0;
    step();
    chk("rst_hold_idone", idone, 0);
    rst_ni = 1'b1;
    step();
    chk("after_rst_idone", idone, 0);
    run_burst(1'b0, 30'h80, 1'b0);
    dreq = 1'b0;
    step();
    chk("end_ddone", ddone, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
